// File: rtl/alu_control_unit_if.sv
// Bus between the multicycle control unit and the rest of the 8-bit CPU:
// instruction memory, the ALU flag outputs and the register-file/ALU controls.
interface alu_control_unit_if #(
  parameter int WIDTH_DATA_LENGTH   = 8,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int WIDTH_PC_LENGTH     = 8
) ();
  logic                           en;
  logic [WIDTH_DATA_LENGTH-1:0]   instr;
  logic                           cf;
  logic                           zf;
  logic [WIDTH_PC_LENGTH-1:0]     pc;
  logic [WIDTH_ALUSEL_LENGTH-1:0] alusel;
  logic                           writecz;
  logic [1:0]                     regsela;
  logic [1:0]                     regselb;
  logic                           regwrite;
  logic                           halted;

  // The datapath/memory side of the CPU
  modport master (
    output en, instr, cf, zf,
    input  pc, alusel, writecz, regsela, regselb, regwrite, halted
  );

  // The control unit itself
  modport slave (
    input  en, instr, cf, zf,
    output pc, alusel, writecz, regsela, regselb, regwrite, halted
  );
endinterface

// File: rtl/alu_control_unit.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the 8-bit CPU.
// Owns PC, IR and the architectural carry/zero flags; resolves relative jumps.
module alu_control_unit #(
  parameter int WIDTH_DATA_LENGTH   = 8,
  parameter int WIDTH_ALUSEL_LENGTH = 4,
  parameter int WIDTH_PC_LENGTH     = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_control_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t                         state;
  state_t                         next_state;
  logic [WIDTH_PC_LENGTH-1:0]     pc;
  logic [WIDTH_DATA_LENGTH-1:0]   ir;
  logic                           flag_c;
  logic                           flag_z;

  logic [3:0]                     opcode;
  logic [WIDTH_ALUSEL_LENGTH-1:0] op_alusel;
  logic                           op_flags;
  logic                           op_rd;
  logic                           jump_taken;
  logic [WIDTH_PC_LENGTH-1:0]     jump_offset;

  logic [WIDTH_ALUSEL_LENGTH-1:0] alusel;
  logic                           writecz;
  logic [1:0]                     regsela;
  logic [1:0]                     regselb;
  logic                           regwrite;
  logic                           halted;

  assign opcode      = ir[7:4];
  assign jump_offset = {{(WIDTH_PC_LENGTH-4){ir[3]}}, ir[3:0]};

  // Opcode table; unused encodings (1101, 1110) fall through as NOP
  always_comb begin
    op_alusel  = '0;
    op_flags   = 1'b0;
    op_rd      = 1'b0;
    jump_taken = 1'b0;
    case (opcode)
      4'h1: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h1); op_rd = 1'b1; end
      4'h2: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h2); op_flags = 1'b1; op_rd = 1'b1; end
      4'h3: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h4); op_flags = 1'b1; op_rd = 1'b1; end
      4'h4: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h5); op_flags = 1'b1; op_rd = 1'b1; end
      4'h5: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h6); op_flags = 1'b1; op_rd = 1'b1; end
      4'h6: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h7); op_flags = 1'b1; op_rd = 1'b1; end
      4'h7: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h8); op_flags = 1'b1; op_rd = 1'b1; end
      4'h8: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h9); op_flags = 1'b1; op_rd = 1'b1; end
      4'hC: begin op_alusel = WIDTH_ALUSEL_LENGTH'(4'h5); op_flags = 1'b1; end
      4'h9: jump_taken = 1'b1;
      4'hA: jump_taken = flag_c;
      4'hB: jump_taken = flag_z;
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    alusel     = '0;
    writecz    = 1'b0;
    regsela    = 2'b00;
    regselb    = 2'b00;
    regwrite   = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        if (bus.en) next_state = S_DECODE;
      end
      S_DECODE: begin
        alusel     = op_alusel;
        regsela    = ir[3:2];
        regselb    = ir[1:0];
        next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        alusel     = op_alusel;
        regsela    = ir[3:2];
        regselb    = ir[1:0];
        writecz    = op_flags;
        next_state = (opcode == 4'hF) ? S_HALT : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        alusel     = op_alusel;
        regsela    = ir[3:2];
        regselb    = ir[1:0];
        regwrite   = op_rd;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
  end

  // PC already points past the jump when EXECUTE adds the offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && bus.en) begin
        ir <= bus.instr;
        pc <= pc + WIDTH_PC_LENGTH'(1);
      end
      if (state == S_EXECUTE) begin
        if (op_flags) begin
          flag_c <= bus.cf;
          flag_z <= bus.zf;
        end
        if (jump_taken) pc <= pc + jump_offset;
      end
    end
  end

  assign bus.pc       = pc;
  assign bus.alusel   = alusel;
  assign bus.writecz  = writecz;
  assign bus.regsela  = regsela;
  assign bus.regselb  = regselb;
  assign bus.regwrite = regwrite;
  assign bus.halted   = halted;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: directed program snippets plus random programs,
// every cycle compared against an instruction-level model of the CPU control.
module tb_alu_control_unit;

  typedef struct {
    logic [3:0] alu;
    bit         fl;
    bit         rd;
    int         jmp;  // 0 none, 1 always, 2 on carry, 3 on zero
  } op_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] mem [256];
  op_t        opTbl [16];

  int         phase;  // 0 fetch, 1 decode, 2 execute, 3 writeback, 4 halted
  logic [7:0] mPc;
  logic [7:0] mIr;
  bit         mC;
  bit         mZ;

  int errors = 0;
  int checks = 0;

  alu_control_unit_if bus ();

  alu_control_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.instr = mem[bus.pc];

  always #5 clk = ~clk;

  function automatic logic [31:0] observed();
    return {13'd0, bus.pc, bus.alusel, bus.writecz, bus.regsela, bus.regselb,
            bus.regwrite, bus.halted};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, compare, then advance the model
  task automatic applyStimulus(input logic enV, input logic cfV, input logic zfV);
    op_t        op;
    logic [3:0] eAlu = 4'h0;
    logic       eWcz = 1'b0, eRw = 1'b0, eH = 1'b0;
    logic [1:0] eA = 2'b00, eB = 2'b00;
    bit         taken;
    @(negedge clk);
    bus.en = enV;
    bus.cf = cfV;
    bus.zf = zfV;
    #1;
    op = opTbl[mIr[7:4]];
    if (phase >= 1 && phase <= 3) begin
      eAlu = op.alu;
      eA   = mIr[3:2];
      eB   = mIr[1:0];
    end
    if (phase == 2) eWcz = op.fl;
    if (phase == 3) eRw = op.rd;
    if (phase == 4) eH = 1'b1;
    checkOutput($sformatf("cycle_ph%0d", phase), observed(),
                {13'd0, mPc, eAlu, eWcz, eA, eB, eRw, eH});
    case (phase)
      0: if (enV) begin
        mIr   = mem[mPc];
        mPc   = mPc + 8'd1;
        phase = 1;
      end
      1: phase = 2;
      2: begin
        taken = (op.jmp == 1) || (op.jmp == 2 && mC) || (op.jmp == 3 && mZ);
        if (op.fl) begin
          mC = cfV;
          mZ = zfV;
        end
        if (taken) mPc = 8'(int'(mPc) + int'($signed(mIr[3:0])));
        phase = (mIr[7:4] == 4'hF) ? 4 : 3;
      end
      3: phase = 0;
      default: phase = 4;
    endcase
  endtask

  task automatic runCycles(input int n, input logic enV, input logic cfV, input logic zfV);
    for (int i = 0; i < n; i++) applyStimulus(enV, cfV, zfV);
  endtask

  // Asynchronous reset, released at a falling edge with En low
  task automatic applyReset();
    bus.en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("reset_async", observed(), 32'd0);
    mPc   = 8'd0;
    mIr   = 8'd0;
    mC    = 1'b0;
    mZ    = 1'b0;
    phase = 0;
    @(negedge clk);
    #1;
    checkOutput("reset_hold", observed(), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic clearMem();
    foreach (mem[i]) mem[i] = 8'h00;
  endtask

  initial begin
    opTbl[0]  = '{4'h0, 1'b0, 1'b0, 0};
    opTbl[1]  = '{4'h1, 1'b0, 1'b1, 0};
    opTbl[2]  = '{4'h2, 1'b1, 1'b1, 0};
    opTbl[3]  = '{4'h4, 1'b1, 1'b1, 0};
    opTbl[4]  = '{4'h5, 1'b1, 1'b1, 0};
    opTbl[5]  = '{4'h6, 1'b1, 1'b1, 0};
    opTbl[6]  = '{4'h7, 1'b1, 1'b1, 0};
    opTbl[7]  = '{4'h8, 1'b1, 1'b1, 0};
    opTbl[8]  = '{4'h9, 1'b1, 1'b1, 0};
    opTbl[9]  = '{4'h0, 1'b0, 1'b0, 1};
    opTbl[10] = '{4'h0, 1'b0, 1'b0, 2};
    opTbl[11] = '{4'h0, 1'b0, 1'b0, 3};
    opTbl[12] = '{4'h5, 1'b1, 1'b0, 0};
    opTbl[13] = '{4'h0, 1'b0, 1'b0, 0};
    opTbl[14] = '{4'h0, 1'b0, 1'b0, 0};
    opTbl[15] = '{4'h0, 1'b0, 1'b0, 0};
    bus.en = 1'b0;
    bus.cf = 1'b0;
    bus.zf = 1'b0;
    clearMem();
    #2;

    // ADD R0,R1
    mem[0] = 8'h31;
    applyReset();
    runCycles(4, 1'b1, 1'b1, 1'b0);
    checkOutput("pc_after_add", {24'd0, bus.pc}, 32'h01);

    // CMP sets Z, JZ +3 from address 1
    clearMem();
    mem[0] = 8'hC1;
    mem[1] = 8'hB3;
    applyReset();
    runCycles(8, 1'b1, 1'b0, 1'b1);
    checkOutput("pc_jz_taken", {24'd0, bus.pc}, 32'h05);

    // JC -8 at address 2, not taken then taken with wrap
    clearMem();
    mem[0] = 8'hC0;
    mem[2] = 8'hA8;
    applyReset();
    runCycles(12, 1'b1, 1'b0, 1'b0);
    checkOutput("pc_jc_not_taken", {24'd0, bus.pc}, 32'h03);
    applyReset();
    runCycles(12, 1'b1, 1'b1, 1'b0);
    checkOutput("pc_jc_taken", {24'd0, bus.pc}, 32'hFB);
    runCycles(20, 1'b1, 1'b0, 1'b0);
    checkOutput("pc_wrap", {24'd0, bus.pc}, 32'h00);

    // MOV must leave the carry from CMP intact for the following JC +2
    clearMem();
    mem[0] = 8'hC0;
    mem[1] = 8'h12;
    mem[2] = 8'hA2;
    applyReset();
    runCycles(4, 1'b1, 1'b1, 1'b1);
    runCycles(8, 1'b1, 1'b0, 1'b0);
    checkOutput("pc_mov_keeps_flags", {24'd0, bus.pc}, 32'h05);

    // En low holds FETCH
    clearMem();
    mem[0] = 8'h31;
    applyReset();
    runCycles(3, 1'b0, 1'b0, 1'b0);
    checkOutput("pc_en_low", {24'd0, bus.pc}, 32'h00);
    runCycles(4, 1'b1, 1'b0, 1'b0);
    checkOutput("pc_en_high", {24'd0, bus.pc}, 32'h01);

    // HALT is absorbing
    clearMem();
    mem[0] = 8'hF0;
    applyReset();
    runCycles(15, 1'b1, 1'b1, 1'b1);
    checkOutput("halt_state", {23'd0, bus.pc, bus.halted}, {23'd0, 8'h01, 1'b1});

    // Reset during EXECUTE of ADD
    clearMem();
    mem[0] = 8'h31;
    applyReset();
    runCycles(3, 1'b1, 1'b1, 1'b1);
    applyReset();
    checkOutput("pc_after_abort", {24'd0, bus.pc}, 32'h00);
    runCycles(4, 1'b1, 1'b0, 1'b0);

    // Random programs without HALT, occasional En gaps and resets
    foreach (mem[i]) begin
      mem[i] = 8'($urandom);
      if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'($urandom_range(0, 14));
    end
    applyReset();
    for (int i = 0; i < 2500; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 299) == 0) applyReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Multicycle sequencer for the 8-bit simple CPU; the control-side counterpart of the ALU.
- Fetches instruction bytes and decodes them into ALUSel, WriteCZ, register-file selects and write enable.
- Consumes the ALU's CF/ZF outputs into architectural flags and resolves conditional relative jumps.
- Sits between instruction memory (combinational read), the register file and the ALU.

Parameters:
WIDTH_DATA_LENGTH, 8, instruction/data byte width
WIDTH_ALUSEL_LENGTH, 4, ALU operation select width
WIDTH_PC_LENGTH, 8, program counter width

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
En  input  1  run enable; sampled only in FETCH
Instr  input  8  instruction memory read data for address PC, valid combinationally
CF  input  1  ALU carry flag
ZF  input  1  ALU zero flag
PC  output  8  instruction memory address
ALUSel  output  4  ALU operation select
WriteCZ  output  1  ALU flag update strobe
RegSelA  output  2  register file read port A (Rd)
RegSelB  output  2  register file read port B (Rb)
RegWrite  output  1  register file write enable; destination = RegSelA
Halted  output  1  high in HALT state

Behaviour:
- Reset (async, Rst_n=0): state=FETCH, PC=0, IR=0, FlagC=FlagZ=0. All outputs 0.
- Instruction format: IR[7:4] opcode, IR[3:2] Rd, IR[1:0] Rb. For jumps, IR[3:0] is a signed offset (-8..+7).
- Opcodes (ALUSel, writes flags, writes Rd):
  - 0000 NOP (-, no, no)
  - 0001 MOV (0001, no, yes)
  - 0010 INC (0010, yes, yes)
  - 0011 ADD (0100, yes, yes)
  - 0100 SUB (0101, yes, yes)
  - 0101 AND (0110, yes, yes)
  - 0110 OR (0111, yes, yes)
  - 0111 SHR (1000, yes, yes)
  - 1000 SHL (1001, yes, yes)
  - 1100 CMP (0101, yes, no)
  - 1001 JMP; 1010 JC (FlagC); 1011 JZ (FlagZ)
  - 1111 HALT
  - 1101 and 1110 execute as NOP.
- FSM: FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is absorbing.
- FETCH with En=1: IR<=Instr, PC<=PC+1 (mod 256), go to DECODE. With En=0: hold state, PC and IR.
- DECODE: ALUSel, RegSelA and RegSelB driven from IR. WriteCZ=0, RegWrite=0. No state change other than advancing.
- EXECUTE:
  - ALUSel, RegSelA and RegSelB held.
  - WriteCZ=1 for flag-writing ops only.
  - At the clock edge ending EXECUTE with WriteCZ=1: FlagC<=CF, FlagZ<=ZF.
  - Taken jump: PC<=PC+sext(IR[3:0]), mod 256. PC already points to the instruction after the jump.
  - HALT: go to HALT instead of WRITEBACK.
- WRITEBACK: ALUSel, RegSelA and RegSelB held. RegWrite=1 for Rd-writing ops. WriteCZ=0.
- Outside DECODE/EXECUTE/WRITEBACK: ALUSel=0000, RegSel=0.
- CPI: 4 cycles for every non-halt instruction.
- HALT: Halted=1, all strobes 0, PC frozen; exit only by reset.
- Outputs are combinational from state and IR; PC, IR and flags are registered.
- Reset mid-instruction aborts it; no register write or flag update occurs after Rst_n falls.
- Flags are unchanged by NOP, MOV and jumps.

Test Plan:
- Reset, En=1, mem[0]=0x31 (ADD R0,R1) -> PC=1 after FETCH; ALUSel=0100 in DECODE/EXECUTE/WRITEBACK; WriteCZ=1 only in EXECUTE; RegWrite=1 only in WRITEBACK, RegSelA=0, RegSelB=1.
- CMP with CF=0, ZF=1 in EXECUTE, then mem[1]=0xB3 (JZ +3) -> RegWrite=0 throughout CMP; FlagZ=1; PC=5 at next FETCH.
- FlagC=0, JC 0xA8 (-8) at address 0x02 -> not taken, PC=3. Repeat with FlagC=1 -> PC=0xFB (wrap-around).
- Sequential fetch from PC=0xFF -> PC=0x00.
- 0x12 (MOV) -> WriteCZ never 1; flags unchanged.
- En=0 for 3 cycles in FETCH -> PC and IR stable, no strobes. Raise En -> normal fetch.
- HALT 0xF0 -> Halted=1 and PC frozen for 10+ cycles.
- Pull Rst_n low during EXECUTE of ADD -> immediate zero outputs; no RegWrite pulse; PC=0 after release.
